hex_scan_ctrl: RTL and testbench

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

---
 rtl/hex_scan_pkg.sv | 17 +
 rtl/SevenSegment_decoder.sv | 39 +++
 rtl/hex_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the hex scan display controller.
package hex_scan_pkg;

    // Controller FSM: wait for a value, scan digits MSD->LSD, one-cycle done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Active-low pattern with every segment and the DP dark.
    localparam logic [7:0] BLANK_PATTERN = 8'hFF;

    // Active-low segments 6..0 all dark (DP handled separately).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/SevenSegment_decoder.sv
// Hex nibble to active-low seven-segment pattern, with decimal point and blanking.
module SevenSegment_decoder
    import hex_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [6:0] segs;

    // Segment lookup; a blanked digit goes dark but still honours its DP.
    always_comb begin
        segs = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: segs = 7'h40;
                4'h1: segs = 7'h79;
                4'h2: segs = 7'h24;
                4'h3: segs = 7'h30;
                4'h4: segs = 7'h19;
                4'h5: segs = 7'h12;
                4'h6: segs = 7'h02;
                4'h7: segs = 7'h78;
                4'h8: segs = 7'h00;
                4'h9: segs = 7'h10;
                4'hA: segs = 7'h08;
                4'hB: segs = 7'h03;
                4'hC: segs = 7'h46;
                4'hD: segs = 7'h21;
                4'hE: segs = 7'h06;
                default: segs = 7'h0E;
            endcase
        end
        seg = {~dp, segs};
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Multi-digit hex display controller: accepts a value, decodes it one digit
// per cycle through a single shared decoder, and blinks the whole display.
//
// Load handshake: a transfer happens on a rising edge where load_valid and
// load_ready are both 1. load_ready is high only while idle; the source must
// hold value/dp_mask/lz_blank stable with load_valid high until that edge,
// and any load_valid seen while busy is simply ignored.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic [8*NUM_DIGITS-1:0] hex,
    output logic                    update_done,
    output scan_state_e             dbg_state
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IW-1:0] IDX_MSD    = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

    scan_state_e   state, state_next;
    logic          accept;

    logic [3:0]    shadow_value [NUM_DIGITS];
    logic          shadow_dp    [NUM_DIGITS];
    logic [7:0]    hex_reg      [NUM_DIGITS];
    logic [IW-1:0] idx;
    logic          lz_active;

    logic [3:0]    cur_nibble;
    logic          cur_dp;
    logic          cur_blank;
    logic [7:0]    dec_out;

    logic [CW-1:0] blink_cnt;
    logic          phase_on;

    assign accept    = load_valid & load_ready;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/pulse outputs.
    always_comb begin
        state_next  = state;
        load_ready  = 1'b0;
        update_done = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (idx == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                update_done = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Current digit seen by the shared decoder; leading zeros blank except digit 0.
    always_comb begin
        cur_nibble = shadow_value[idx];
        cur_dp     = shadow_dp[idx];
        cur_blank  = lz_active && (cur_nibble == 4'd0) && (idx != '0);
    end

    SevenSegment_decoder u_decoder (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (dec_out)
    );

    // Shadow capture on transfer, then digit index and blanking tracking while scanning.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_value[i] <= 4'd0;
                shadow_dp[i]    <= 1'b0;
            end
            idx       <= '0;
            lz_active <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_value[i] <= value[4*i +: 4];
                shadow_dp[i]    <= dp_mask[i];
            end
            idx       <= IDX_MSD;
            lz_active <= lz_blank;
        end else if (state == SCAN) begin
            if (cur_nibble != 4'd0) begin
                lz_active <= 1'b0;
            end
            if (idx != '0) begin
                idx <= idx - IW'(1);
            end
        end
    end

    // Display registers: one decoded digit written per scan cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_reg[i] <= BLANK_PATTERN;
            end
        end else if (state == SCAN) begin
            hex_reg[idx] <= dec_out;
        end
    end

    // Blink timebase: phase flips every BLINK_DIV cycles; held on while disabled.
    always_ff @(posedge clk) begin
        if (reset || !blink_en) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    // Output: registered digits, forced dark during the off phase.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex_out
        assign hex[8*g +: 8] = hex_reg[g] | {8{~phase_on}};
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl with a digit-level reference model.
module tb_hex_scan_ctrl;
    import hex_scan_pkg::*;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam logic [47:0] ALL_FF = {ND{8'hFF}};

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [23:0]   value;
    logic [5:0]    dp_mask;
    logic          lz_blank;
    logic          blink_en;
    logic [47:0]   hex;
    logic          update_done;
    scan_state_e   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [47:0] prev_disp;

    // Active-low segment shapes of the hex glyphs 0..F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_scan_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .value       (value),
        .dp_mask     (dp_mask),
        .lz_blank    (lz_blank),
        .blink_en    (blink_en),
        .hex         (hex),
        .update_done (update_done),
        .dbg_state   (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Expected final display: digits above the most significant nonzero digit
    // are dark when blanking is on; digit 0 always shows.
    function automatic logic [47:0] model(logic [23:0] v, logic [5:0] dp, logic lz);
        logic [47:0] r;
        int msd;
        msd = 0;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < ND; i++) begin
            if (lz && i > msd) r[8*i +: 8] = {~dp[i], 7'h7F};
            else               r[8*i +: 8] = {~dp[i], glyph[v[4*i +: 4]]};
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a value and advance through the accepting edge.
    task automatic accept(input logic [23:0] v, input logic [5:0] dp, input logic lz,
                          output int waited);
        value      = v;
        dp_mask    = dp;
        lz_blank   = lz;
        load_valid = 1'b1;
        waited     = 0;
        while (!load_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!load_ready) check("accept_timeout", 64'(load_ready), 64'd1);
        step();
        check("state_scan_after_accept", 64'(dbg_state), 64'(SCAN));
        check("no_done_at_accept", 64'(update_done), 64'd0);
    endtask

    // Follow the scan digit by digit, then the done pulse and return to idle.
    task automatic scan_check(input logic [47:0] exp_new);
        logic [47:0] exp;
        for (int k = 1; k <= ND; k++) begin
            step();
            exp = prev_disp;
            for (int i = ND - k; i < ND; i++) exp[8*i +: 8] = exp_new[8*i +: 8];
            check("scan_digits", 64'(hex), 64'(exp));
            check("done_timing", 64'(update_done), (k == ND) ? 64'd1 : 64'd0);
            check("ready_busy", 64'(load_ready), 64'd0);
        end
        step();
        check("done_one_cycle", 64'(update_done), 64'd0);
        check("ready_after_done", 64'(load_ready), 64'd1);
        check("state_idle", 64'(dbg_state), 64'(IDLE));
        prev_disp = exp_new;
    endtask

    initial begin
        int w;
        logic [23:0] rv;
        logic [5:0]  rd;
        logic        rl;

        reset      = 1'b1;
        load_valid = 1'b0;
        value      = '0;
        dp_mask    = '0;
        lz_blank   = 1'b0;
        blink_en   = 1'b0;
        prev_disp  = ALL_FF;
        step();
        step();
        reset = 1'b0;
        check("reset_hex", 64'(hex), 64'(ALL_FF));
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        check("reset_ready", 64'(load_ready), 64'd1);
        check("reset_done", 64'(update_done), 64'd0);

        // Leading-zero blanking with an embedded zero.
        accept(24'h00A05F, 6'b000000, 1'b1, w);
        load_valid = 1'b0;
        scan_check(48'hFFFF88C0928E);

        // Zero value keeps digit 0.
        accept(24'h000000, 6'b000000, 1'b1, w);
        load_valid = 1'b0;
        scan_check(48'hFFFFFFFFFFC0);

        // No blanking, one decimal point on a zero digit.
        accept(24'h000001, 6'b000100, 1'b0, w);
        load_valid = 1'b0;
        scan_check(48'hC0C0C040C0F9);

        // Blanked digit keeps its DP.
        accept(24'h000007, 6'b100000, 1'b1, w);
        load_valid = 1'b0;
        scan_check(model(24'h000007, 6'b100000, 1'b1));
        check("blank_dp_digit5", 64'(hex[47:40]), 64'h7F);

        // A request held during a scan waits until the cycle after done.
        accept(24'h00A05F, 6'b000000, 1'b1, w);
        value      = 24'h123456;
        dp_mask    = 6'b000011;
        lz_blank   = 1'b0;
        load_valid = 1'b1;
        scan_check(48'hFFFF88C0928E);
        accept(24'h123456, 6'b000011, 1'b0, w);
        check("held_accept_wait", 64'(w), 64'd0);
        load_valid = 1'b0;
        scan_check(model(24'h123456, 6'b000011, 1'b0));

        // Randomized values with varying numbers of leading zeros.
        for (int n = 0; n < 12; n++) begin
            rv = 24'($urandom) >> (4 * $urandom_range(0, ND));
            rd = 6'($urandom);
            rl = 1'($urandom_range(0, 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            accept(rv, rd, rl, w);
            load_valid = 1'b0;
            scan_check(model(rv, rd, rl));
        end

        // Blinking: four cycles shown, four cycles dark, counted from enable.
        blink_en = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            step();
            check("blink_phase", 64'(hex), (((k / BD) % 2) == 0) ? 64'(prev_disp) : 64'(ALL_FF));
        end
        blink_en = 1'b0;
        step();
        check("blink_off_restore", 64'(hex), 64'(prev_disp));

        // Reset in the third scan cycle aborts the update.
        accept(24'h987654, 6'b111111, 1'b0, w);
        load_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_hex", 64'(hex), 64'(ALL_FF));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        check("abort_ready", 64'(load_ready), 64'd1);
        check("abort_done", 64'(update_done), 64'd0);
        for (int k = 0; k < ND + 2; k++) begin
            step();
            check("abort_no_done", 64'(update_done), 64'd0);
        end
        prev_disp = ALL_FF;

        // Reset wins over a simultaneous handshake.
        value      = 24'h111111;
        load_valid = 1'b1;
        reset      = 1'b1;
        step();
        reset      = 1'b0;
        load_valid = 1'b0;
        check("reset_priority_state", 64'(dbg_state), 64'(IDLE));

        // Normal operation after the abort.
        accept(24'h0BEEF0, 6'b010000, 1'b1, w);
        load_valid = 1'b0;
        scan_check(model(24'h0BEEF0, 6'b010000, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
